// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping-bus arbiter: bus message codes,
// arbiter FSM encoding and MESI state codes used by the attached controllers.
package snoop_pkg;

  localparam logic [1:0] MSG_NONE    = 2'b00;
  localparam logic [1:0] MSG_RD_MISS = 2'b01;
  localparam logic [1:0] MSG_WR_MISS = 2'b10;
  localparam logic [1:0] MSG_INV     = 2'b11;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BCAST = 3'd1,
    ST_SNOOP = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_DONE  = 3'd5
  } arb_state_e;

endpackage

// File: rtl/snoop_bus_arbiter_rr_select.sv
// Combinational round-robin picker: the first requester after i_ptr
// (wrapping) wins; returns one-hot, index and a valid flag.
module rr_select
  import snoop_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  int w_j;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_j      = 0;
    // Scan from farthest to nearest so the nearest requester is written last.
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(i_ptr) + k) % N;
      if (i_req[w_j]) begin
        o_idx   = IDX_W'(w_j);
        o_valid = 1'b1;
      end
    end
    if (o_valid) o_onehot[o_idx] = 1'b1;
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter/broadcaster for MESI controllers. Optional transaction
// statistics counters are enabled by defining SNOOP_ARB_STATS_EN.
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 3
) (
  input  logic                        clock,
  input  logic                        Reset,
  input  logic [2*N_CORES-1:0]        req_msg,
  input  logic [ADDR_W*N_CORES-1:0]   req_addr,
  input  logic [N_CORES-1:0]          snoop_hit,
  input  logic [N_CORES-1:0]          snoop_wb,
  output logic                        bus_valid,
  output logic [1:0]                  bus_msg,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [$clog2(N_CORES)-1:0]  bus_src,
  output logic [N_CORES-1:0]          grant,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [N_CORES-1:0]          done,
  output logic                        shared_out
`ifdef SNOOP_ARB_STATS_EN
  ,
  output logic [15:0]                 txn_count,
  output logic [15:0]                 wb_count,
  output logic [15:0]                 inv_count
`endif
);

  localparam int IDX_W = $clog2(N_CORES);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_e         r_state, w_state_n;
  logic [IDX_W-1:0]   r_win, w_win_n, r_rr_ptr;
  logic [1:0]         r_msg, w_msg_n;
  logic [ADDR_W-1:0]  r_addr, w_addr_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n;
  logic               r_post_done;
  logic               r_via_wb;

  logic [N_CORES-1:0] w_req_vec, w_sel_oh, w_win_oh, w_hit_masked, w_wb_masked;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_sel_valid;

  // The previous winner is masked for one IDLE cycle to absorb a late deassert.
  always_comb begin
    w_req_vec = '0;
    for (int i = 0; i < N_CORES; i++) begin
      w_req_vec[i] = (req_msg[2*i +: 2] != MSG_NONE) &&
                     !(r_post_done && (r_win == IDX_W'(i)));
    end
  end

  rr_select #(.N(N_CORES), .IDX_W(IDX_W)) u_rr_select (
    .i_req    (w_req_vec),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_sel_oh),
    .o_idx    (w_sel_idx),
    .o_valid  (w_sel_valid)
  );

  assign w_win_oh     = N_CORES'(1) << r_win;
  assign w_hit_masked = snoop_hit & ~w_win_oh;
  assign w_wb_masked  = snoop_wb & ~w_win_oh;

  always_comb begin
    w_state_n = r_state;
    w_win_n   = r_win;
    w_msg_n   = r_msg;
    w_addr_n  = r_addr;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_sel_valid) begin
          w_win_n   = w_sel_idx;
          w_msg_n   = req_msg[2*int'(w_sel_idx) +: 2];
          w_addr_n  = req_addr[ADDR_W*int'(w_sel_idx) +: ADDR_W];
          w_state_n = ST_BCAST;
        end
      end
      ST_BCAST: w_state_n = ST_SNOOP;
      ST_SNOOP: begin
        if (r_msg == MSG_INV) begin
          w_state_n = ST_DONE;
        end else if (|w_wb_masked) begin
          w_state_n = ST_WB;
        end else begin
          w_state_n = ST_MEM;
          w_cnt_n   = CNT_LOAD;
        end
      end
      ST_MEM: begin
        if (r_cnt == '0) w_state_n = ST_DONE;
        else             w_cnt_n   = r_cnt - 1'b1;
      end
      ST_WB:   w_state_n = ST_DONE;
      ST_DONE: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered and
  // line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_win       <= '0;
      r_msg       <= MSG_NONE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_rr_ptr    <= IDX_W'(N_CORES - 1);
      r_post_done <= 1'b0;
      r_via_wb    <= 1'b0;
      bus_valid   <= 1'b0;
      bus_msg     <= MSG_NONE;
      bus_addr    <= '0;
      bus_src     <= '0;
      grant       <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      done        <= '0;
      shared_out  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_win       <= w_win_n;
      r_msg       <= w_msg_n;
      r_addr      <= w_addr_n;
      r_cnt       <= w_cnt_n;
      r_post_done <= (r_state == ST_DONE);
      r_via_wb    <= (r_state == ST_WB);
      if (r_state == ST_DONE)  r_rr_ptr   <= r_win;
      if (r_state == ST_SNOOP) shared_out <= |w_hit_masked;
      bus_valid <= (w_state_n == ST_BCAST);
      bus_msg   <= (w_state_n == ST_BCAST) ? w_msg_n  : MSG_NONE;
      bus_addr  <= (w_state_n == ST_BCAST) ? w_addr_n : '0;
      bus_src   <= (w_state_n == ST_BCAST) ? w_win_n  : '0;
      grant     <= (w_state_n == ST_BCAST) ? w_sel_oh : '0;
      mem_rd    <= (w_state_n == ST_MEM);
      mem_wr    <= (w_state_n == ST_WB);
      done      <= (w_state_n == ST_DONE) ? w_win_oh : '0;
    end
  end

`ifdef SNOOP_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (Reset) begin
      txn_count <= '0;
      wb_count  <= '0;
      inv_count <= '0;
    end else if (r_state == ST_DONE) begin
      txn_count <= txn_count + 16'd1;
      if (r_via_wb)         wb_count  <= wb_count + 16'd1;
      if (r_msg == MSG_INV) inv_count <= inv_count + 16'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = r_via_wb;
`endif

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Shared snooping-bus arbiter and broadcaster for the MESI cache controllers.
- Collects each core's bus request (the controller's `Bus_out` encoding plus line address) and grants one core per transaction, round-robin.
- Broadcasts the winning message to all cores as their `Bus_in`, collects snoop responses, and sequences the memory read or write-back.
- Returns a shared/not-shared indication that the requester uses as its CPU-request LSB on a read miss.

## Interface
Parameters:
- `N_CORES`, 4: number of attached cache controllers (2..8).
- `ADDR_W`, 8: line-address width.
- `MEM_LAT`, 3: memory read latency in cycles (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `req_msg`  in  2*N_CORES  per-core request, core i at [2i+1:2i]:
  - 00 none, 01 read miss, 10 write miss, 11 invalidate.
  - Held until that core's `done`.
- `req_addr`  in  ADDR_W*N_CORES  per-core line address, valid while `req_msg`≠00.
- `snoop_hit`  in  N_CORES  core holds the broadcast line valid (S/E/M).
- `snoop_wb`  in  N_CORES  core supplies write-back (its `Mem_out`=01).
- `bus_valid`  out  1  broadcast cycle strobe.
- `bus_msg`  out  2  broadcast message (drives every core's `Bus_in`; requester masks its own).
- `bus_addr`  out  ADDR_W  broadcast address.
- `bus_src`  out  $clog2(N_CORES)  winner index.
- `grant`  out  N_CORES  one-hot, high during BCAST only.
- `mem_rd`  out  1  memory read active.
- `mem_wr`  out  1  one-cycle write-back strobe.
- `done`  out  N_CORES  one-hot, one-cycle completion pulse to the winner.
- `shared_out`  out  1  valid with `done`: any non-requester asserted `snoop_hit`.

## Operation
FSM states: IDLE, BCAST, SNOOP, MEM, WB, DONE.
- IDLE:
  - If any request is non-zero, pick the winner by round-robin starting at `rr_ptr+1` (mod N_CORES).
  - Latch winner id, message and address; go to BCAST.
- BCAST:
  - `bus_valid`=1; `bus_msg`, `bus_addr`, `bus_src` driven from the latch; `grant[winner]`=1.
  - Go to SNOOP.
- SNOOP:
  - Sample `snoop_hit`/`snoop_wb` with the winner's bit masked off.
  - `shared_out` is registered here (OR of masked hits).
  - msg=11 → DONE; any masked `snoop_wb` → WB; else → MEM.
- MEM:
  - `mem_rd`=1; a down-counter loaded with MEM_LAT-1 decrements each cycle.
  - Exit to DONE when the counter reaches 0, so `mem_rd` is high for exactly MEM_LAT cycles.
- WB: `mem_wr`=1 for one cycle (owner supplies data, memory read aborted) → DONE.
- DONE: `done[winner]`=1; `rr_ptr`←winner → IDLE.
- Post-DONE mask: in the IDLE cycle directly after DONE, the previous winner's request is masked. This tolerates a one-cycle-late deassert.
- Message 00 is never granted.
- Requests arriving or changing outside IDLE are ignored until IDLE.
- Reset (any state, mid-transaction included):
  - State → IDLE; `rr_ptr`←N_CORES-1, so core 0 has first priority.
  - Counter cleared; all outputs 0; latches cleared.

## Timing
- Request first seen in IDLE at cycle t; BCAST t+1, SNOOP t+2.
- Invalidate: DONE t+3.
- Write-back: WB t+3, DONE t+4.
- Read/write miss with no write-back: MEM t+3..t+2+MEM_LAT, DONE t+3+MEM_LAT.
- Back-to-back transactions: next BCAST no earlier than two cycles after DONE.
- Snoop inputs are sampled only in SNOOP, one cycle after broadcast. Controllers must respond combinationally from the BCAST-cycle `Bus_in` or with exactly one register.
- All outputs are registered.

## Configuration
- `SNOOP_ARB_STATS_EN` defined:
  - Adds outputs `txn_count` [15:0], `wb_count` [15:0] and `inv_count` [15:0].
  - Each increments in DONE according to the transaction type, wraps at 0xFFFF→0, and is cleared by `Reset`.
- Undefined: these ports and counters do not exist.

## Structure
- Shared package `snoop_pkg` holds:
  - bus-message localparams (MSG_NONE=00, MSG_RD_MISS=01, MSG_WR_MISS=10, MSG_INV=11);
  - the FSM state encoding;
  - MESI state codes (I=00, S=01, E=10, M=11).
- One sub-module: `rr_select`, a combinational round-robin picker (request vector + pointer → one-hot + index), instantiated once.

## Test plan
- Reset, then core 2 issues 01 @0x3A, no hits, MEM_LAT=3 → BCAST msg=01 addr=0x3A src=2; `mem_rd` high 3 cycles; `done[2]` at t+6; `shared_out`=0.
- Cores 0,1,3 request simultaneously after reset → grants in order 0,1,3; then core 0 re-requests → core 0 wins only after 3.
- Core 1 sends 10, core 3 asserts `snoop_wb` → `mem_wr` one pulse at t+3, `mem_rd` never asserted, `done[1]` at t+4.
- Core 0 sends 11, cores 1,2 `snoop_hit` → no memory activity, `done[0]` at t+3, `shared_out`=1.
- Requester asserts its own `snoop_hit`/`snoop_wb` → ignored: `shared_out`=0, no WB path taken.
- `Reset` asserted during MEM → next cycle all outputs 0, state IDLE; the pending request is re-arbitrated with core 0 priority.
